pmod_gpio_bank: RTL and testbench

- Parametrised successor to the fixed 2-PMOD GPIO hookup on the board top-levels.
- Drives PORTS x PIN_W pads as a GPIO bank with registered outputs and per-pin output enable.
- Inputs pass through a synchroniser, then a per-pin debouncer, then an edge detector that sets sticky interrupt-pending bits.
- Sits between Murax gpioA (write/writeEnable/read) and the board pads.

---
 rtl/pmod_gpio_bank.sv | 161 ++++++++++++++++
 tb/tb_pmod_gpio_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmod_gpio_bank.sv
// pmod_gpio_bank: PORTS x PIN_W PMOD pad GPIO bank with a synchronised, debounced input path and sticky edge interrupts.
// Latency: pad out/oe 1 cycle after write/writeEnable; pad in -> gpio_read at least SYNC_STAGES+limit+1 cycles.
// Backpressure: none. All inputs are sampled every cycle and nothing can stall.
//
// Ports:
//   io_mainClk, io_asyncResetn            clock (rising edge), async active-low reset
//   io_gpio_write / io_gpio_writeEnable   CPU output data / per-pin output enable
//   io_gpio_read                          debounced pin state
//   io_pmod_in / io_pmod_out / io_pmod_oe raw async pad input, pad output data, pad drive enable
//   io_debounceLimit                      stable cycles required before an input change is accepted
//   io_riseMask / io_fallMask             per-pin edge enables for the pending bits
//   io_irqClear                           write-1-to-clear pulse for pending bits
//   io_irqPending / io_irq                sticky pending bits and their registered OR
//   io_pwmDuty                            per-port 8-bit PWM duty (only with PMOD_GPIO_PWM_EN)
//
// Optional feature macro: PMOD_GPIO_PWM_EN. It adds io_pwmDuty and a free-running 8-bit counter
// that gates each pin's output data.
module pmod_gpio_bank #(
  parameter int PORTS       = 2,
  parameter int PIN_W       = 8,
  parameter int SYNC_STAGES = 2,   // legal values 2..4
  parameter int DEBOUNCE_W  = 16
) (
  input  logic                     io_mainClk,
  input  logic                     io_asyncResetn,
  input  logic [PORTS*PIN_W-1:0]   io_gpio_write,
  input  logic [PORTS*PIN_W-1:0]   io_gpio_writeEnable,
  output logic [PORTS*PIN_W-1:0]   io_gpio_read,
  input  logic [PORTS*PIN_W-1:0]   io_pmod_in,
  output logic [PORTS*PIN_W-1:0]   io_pmod_out,
  output logic [PORTS*PIN_W-1:0]   io_pmod_oe,
  input  logic [DEBOUNCE_W-1:0]    io_debounceLimit,
  input  logic [PORTS*PIN_W-1:0]   io_riseMask,
  input  logic [PORTS*PIN_W-1:0]   io_fallMask,
  input  logic [PORTS*PIN_W-1:0]   io_irqClear,
`ifdef PMOD_GPIO_PWM_EN
  input  logic [PORTS*8-1:0]       io_pwmDuty,
`endif
  output logic [PORTS*PIN_W-1:0]   io_irqPending,
  output logic                     io_irq
);

  localparam int N = PORTS * PIN_W;

  // Synchroniser chain; stage SYNC_STAGES-1 is the only one the debouncer looks at.
  logic [N-1:0]            sync_q [SYNC_STAGES];
  logic [N-1:0]            sync_d [SYNC_STAGES];
  logic [N-1:0]            sync_w;

  logic [DEBOUNCE_W-1:0]   cnt_q [N];
  logic [DEBOUNCE_W-1:0]   cnt_d [N];
  logic [N-1:0]            stable_q, stable_d;
  logic [N-1:0]            stable_dly_q, stable_dly_d;
  logic [N-1:0]            pend_q, pend_d;
  logic                    irq_q, irq_d;
  logic [N-1:0]            out_q, out_d;
  logic [N-1:0]            oe_q, oe_d;
  logic [N-1:0]            rise, fall;

  always_comb begin
    sync_d[0] = io_pmod_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // Debounce: a pin's new level must persist at the synchroniser output for limit+1 consecutive
  // cycles. Any return to the stable level restarts the count. The count is compared against the
  // live limit, so a limit change mid-count applies on the next compare.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != stable_q[i]) begin
        if (cnt_q[i] >= io_debounceLimit) begin
          stable_d[i] = sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edges are taken on the debounced level, one cycle after it changes.
  always_comb begin
    stable_dly_d = stable_q;
    rise         = stable_q & ~stable_dly_q & io_riseMask;
    fall         = ~stable_q & stable_dly_q & io_fallMask;
    // A new edge wins over a clear arriving in the same cycle.
    pend_d       = (pend_q & ~io_irqClear) | rise | fall;
    irq_d        = |pend_q;
  end

`ifdef PMOD_GPIO_PWM_EN
  logic [7:0]   pwm_cnt_q, pwm_cnt_d;
  logic [N-1:0] pwm_gate;

  // Free-running counter; a pin is high while the counter is below its port's duty,
  // so duty=0 never drives high and duty=255 drives high 255 of every 256 cycles.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    for (int i = 0; i < N; i++) begin
      pwm_gate[i] = (pwm_cnt_q < io_pwmDuty[(i / PIN_W) * 8 +: 8]);
    end
    out_d = io_gpio_write & pwm_gate;
    oe_d  = io_gpio_writeEnable;
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  always_comb begin
    out_d = io_gpio_write;
    oe_d  = io_gpio_writeEnable;
  end
`endif

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q     <= '0;
      stable_dly_q <= '0;
      pend_q       <= '0;
      irq_q        <= 1'b0;
      out_q        <= '0;
      oe_q         <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      pend_q       <= pend_d;
      irq_q        <= irq_d;
      out_q        <= out_d;
      oe_q         <= oe_d;
    end
  end

  assign io_gpio_read  = stable_q;
  assign io_pmod_out   = out_q;
  assign io_pmod_oe    = oe_q;
  assign io_irqPending = pend_q;
  assign io_irq        = irq_q;

endmodule

// File: tb/tb_pmod_gpio_bank.sv
// tb_pmod_gpio_bank: directed scenarios plus randomized stimulus against a behavioural model.
// Latency: outputs are checked 1 time unit after each rising clock edge.
// Backpressure: not applicable.
module tb_pmod_gpio_bank;

  localparam int PORTS       = 2;
  localparam int PIN_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE_W  = 16;
  localparam int N           = PORTS * PIN_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          wr, we, pad, rmask, fmask, clr;
  logic [DEBOUNCE_W-1:0] lim;
  logic [PORTS*8-1:0]    duty;
  logic [N-1:0]          rd, out, oe, pend;
  logic                  irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pmod_gpio_bank #(
    .PORTS(PORTS), .PIN_W(PIN_W), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)
  ) dut (
    .io_mainClk          (clk),
    .io_asyncResetn      (rst_n),
    .io_gpio_write       (wr),
    .io_gpio_writeEnable (we),
    .io_gpio_read        (rd),
    .io_pmod_in          (pad),
    .io_pmod_out         (out),
    .io_pmod_oe          (oe),
    .io_debounceLimit    (lim),
    .io_riseMask         (rmask),
    .io_fallMask         (fmask),
    .io_irqClear         (clr),
`ifdef PMOD_GPIO_PWM_EN
    .io_pwmDuty          (duty),
`endif
    .io_irqPending       (pend),
    .io_irq              (irq)
  );

  // ---------------- behavioural reference model ----------------
  // Pad samples travel through a delay queue; a pin's level is accepted once the delayed sample
  // has disagreed with the accepted level for more than `limit` consecutive cycles.
  logic [N-1:0] m_out, m_oe, m_level, m_level_prev, m_pend;
  logic         m_irq;
  logic [7:0]   m_pwm;
  int           m_run [N];
  logic [N-1:0] m_pads [$];
  logic [N-1:0] m_seen, m_next, m_edges, m_gate;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_oe = '0; m_level = '0; m_level_prev = '0; m_pend = '0; m_irq = 1'b0;
      m_pwm = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_pads = {};
      for (int s = 0; s < SYNC_STAGES; s++) m_pads.push_back('0);
    end else begin
      m_seen = m_pads[0];
      m_next = m_level;
      for (int i = 0; i < N; i++) begin
        if (m_seen[i] == m_level[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] > int'(lim)) begin
            m_next[i] = m_seen[i];
            m_run[i]  = 0;
          end
        end
      end
      m_edges = (m_level & ~m_level_prev & rmask) | (~m_level & m_level_prev & fmask);
      m_irq   = (m_pend != '0);
      m_pend  = (m_pend & ~clr) | m_edges;
      m_level_prev = m_level;
      m_level      = m_next;
`ifdef PMOD_GPIO_PWM_EN
      for (int i = 0; i < N; i++) m_gate[i] = (int'(m_pwm) < int'(duty[(i / PIN_W) * 8 +: 8]));
`else
      m_gate = '1;
`endif
      m_out = wr & m_gate;
      m_oe  = we;
      m_pwm = m_pwm + 8'd1;
      m_pads.push_back(pad);
      void'(m_pads.pop_front());
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "/out"},  out,  m_out);
    chk({tag, "/oe"},   oe,   m_oe);
    chk({tag, "/read"}, rd,   m_level);
    chk({tag, "/pend"}, pend, m_pend);
    chk({tag, "/irq"},  irq,  m_irq);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  int cnt_hi [PIN_W];

  initial begin
    wr = '1; we = '1; pad = '0; lim = '0; rmask = '0; fmask = '0; clr = '0; duty = '0;

    // Reset holds every output low even with write/oe all ones.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",  out,  '0);
    chk("rst_oe",   oe,   '0);
    chk("rst_read", rd,   '0);
    chk("rst_pend", pend, '0);
    chk("rst_irq",  irq,  '0);

    // Output path: exactly one cycle from write to pad.
    rst_n = 1'b1; wr = 16'hA5C3; we = 16'hFFFF;
    #1;
    chk("out_pre_edge", out, '0);
    step("out_path");
    chk("out_1cyc", out, 16'hA5C3);
    chk("oe_1cyc",  oe,  16'hFFFF);

    // Debounce accept, limit 4: visible SYNC_STAGES+5 cycles after the step.
    lim = 16'd4;
    repeat (12) step("settle");
    pad[0] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 6; k++) begin
      step("db_accept");
      chk($sformatf("db_accept_k%0d", k), rd[0], (k >= SYNC_STAGES + 5));
    end

    // Debounce reject: 4-cycle then 3-cycle pulses never get through.
    rmask = '1;
    for (int k = 0; k < 30; k++) begin
      pad[3] = (k < 4) || (k >= 14 && k < 17);
      step("db_reject");
      chk("db_reject_read", rd[3], 1'b0);
      chk("db_reject_irq",  irq,   1'b0);
    end

    // Edge / IRQ: pin 0 rises, pin 8 falls.
    rmask = '0; fmask = '0; pad[0] = 1'b0; pad[8] = 1'b1;
    repeat (12) step("edge_prep");
    rmask = 16'h0001; fmask = 16'h0100; pad[0] = 1'b1; pad[8] = 1'b0;
    repeat (12) step("edge_wait");
    chk("edge_pend", pend, 16'h0101);
    chk("edge_irq",  irq,  1'b1);
    clr = 16'h0001;
    step("clr0");
    clr = '0;
    chk("clr0_pend", pend, 16'h0100);
    pad[8] = 1'b1;
    repeat (12) step("pin8_up");
    clr = 16'h0100;
    step("clr8");
    clr = '0;
    chk("clr8_pend", pend, '0);
    step("clr8_irq");
    chk("clr8_irq", irq, 1'b0);
    // Fall on pin 8 lands in the same cycle as a clear of pin 8: the set wins.
    pad[8] = 1'b0;
    repeat (SYNC_STAGES + 5) step("pin8_fall");
    clr = 16'h0100;
    step("set_vs_clr");
    clr = '0;
    chk("set_wins_pend", pend, 16'h0100);
    step("set_wins_irq");
    chk("set_wins_irq", irq, 1'b1);

    // Limit 0: a single-cycle pad pulse is accepted for one cycle and sets rise pending.
    rmask = 16'h0010; fmask = '0; lim = '0; clr = '1;
    step("lim0_clr");
    clr = '0;
    step("lim0_idle");
    pad[4] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step("lim0");
      if (k == 1) pad[4] = 1'b0;
      chk($sformatf("lim0_read_k%0d", k), rd[4],   (k == SYNC_STAGES + 1));
      chk($sformatf("lim0_pend_k%0d", k), pend[4], (k >= SYNC_STAGES + 2));
      chk($sformatf("lim0_irq_k%0d", k),  irq,     (k >= SYNC_STAGES + 3));
    end

    // Reset in the middle of a debounce count.
    lim = 16'd4;
    pad[5] = 1'b1;
    repeat (SYNC_STAGES + 2) step("mid_cnt");
    rst_n = 1'b0;
    #2;
    chk("midrst_read", rd,   '0);
    chk("midrst_pend", pend, '0);
    chk("midrst_irq",  irq,  '0);
    chk("midrst_out",  out,  '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 6; k++) begin
      step("post_rst");
      chk($sformatf("post_rst_read5_k%0d", k), rd[5], (k >= SYNC_STAGES + 5));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) lim = DEBOUNCE_W'($urandom_range(0, 6));
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) pad[i] = ~pad[i];
      if ($urandom_range(0, 39) == 0) begin rmask = N'($urandom); fmask = N'($urandom); end
      clr = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) begin wr = N'($urandom); we = N'($urandom); end
`ifdef PMOD_GPIO_PWM_EN
      if ($urandom_range(0, 99) == 0) duty = (PORTS*8)'($urandom);
`endif
      step("rand");
    end
    clr = '0;

`ifdef PMOD_GPIO_PWM_EN
    // PWM: duty 64 on port 0 gives 64 high cycles in every 256; duty 0 gives none.
    wr = 16'h00FF; duty = '0; duty[7:0] = 8'd64;
    step("pwm_load");
    for (int p = 0; p < PIN_W; p++) cnt_hi[p] = 0;
    for (int c = 0; c < 256; c++) begin
      step("pwm64");
      for (int p = 0; p < PIN_W; p++) cnt_hi[p] += int'(out[p]);
    end
    for (int p = 0; p < PIN_W; p++) chk($sformatf("pwm64_pin%0d", p), cnt_hi[p], 64);
    duty[7:0] = 8'd0;
    step("pwm0_load");
    for (int p = 0; p < PIN_W; p++) cnt_hi[p] = 0;
    for (int c = 0; c < 256; c++) begin
      step("pwm0");
      for (int p = 0; p < PIN_W; p++) cnt_hi[p] += int'(out[p]);
    end
    for (int p = 0; p < PIN_W; p++) chk($sformatf("pwm0_pin%0d", p), cnt_hi[p], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
